// File: rtl/game_state_rx_pkg.sv
// Shared constants and types for the pong game-state link (host serializer and client receiver).
package game_state_rx_pkg;

  localparam logic [7:0]  SYNC_BYTE        = 8'hA5;
  localparam int          PKT_LEN          = 9;
  localparam int          X_W              = 11;
  localparam int          Y_W              = 10;
  localparam int          SCORE_W          = 4;
  localparam int unsigned BYTE_TIMEOUT_CYC = 100_000;
  localparam int unsigned LINK_TIMEOUT_CYC = 6_500_000;

  // One state per packet byte; the CHK state is the last byte of the packet.
  typedef enum logic [$clog2(PKT_LEN+1)-1:0] {
    HUNT, X_HI, X_LO, Y_HI, Y_LO, P_HI, P_LO, SCORE, CHK
  } rx_state_t;

endpackage

// File: rtl/game_state_rx_if.sv
// Byte stream from the UART receiver into the game-state parser.
interface game_state_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, rx_valid);
  modport slave  (input  rx_data, rx_valid);
endinterface

// File: rtl/game_state_rx_link_watchdog.sv
// Generic silence counter: counts enabled cycles since the last clear, flags LIMIT reached.
module link_watchdog #(
  parameter int unsigned LIMIT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign timeout = (count == W'(LIMIT));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !timeout)
      count <= count + W'(1);
  end

endmodule

// File: rtl/game_state_rx.sv
// Client-side game-state receiver: parses 9-byte packets, verifies them, updates outputs atomically.
module game_state_rx
  import game_state_rx_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = BYTE_TIMEOUT_CYC,
  parameter int unsigned LINK_TIMEOUT = LINK_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  game_state_rx_if.slave       rx,
  output logic [X_W-1:0]       x_ball,
  output logic [Y_W-1:0]       y_ball,
  output logic [Y_W-1:0]       y_player_1,
  output logic [SCORE_W-1:0]   player1_score,
  output logic [SCORE_W-1:0]   player2_score,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic [7:0]           err_count,
  output logic                 link_up
);

  rx_state_t state, state_nxt;

  logic good_pkt, bad_pkt, byte_abort, rsv_bad;
  logic byte_to, link_to, gap_clr;

  logic [7:0]           chk_acc;
  logic                 rsv_err;
  logic [X_W-1:0]       x_sh;
  logic [Y_W-1:0]       y_sh, p_sh;
  logic [2*SCORE_W-1:0] score_sh;

  assign gap_clr = rx.rx_valid || (state == HUNT);

  link_watchdog #(.LIMIT(BYTE_TIMEOUT)) u_byte_wd (
    .clk(clk), .rst(rst), .clr(gap_clr), .en(1'b1), .timeout(byte_to)
  );

  link_watchdog #(.LIMIT(LINK_TIMEOUT)) u_link_wd (
    .clk(clk), .rst(rst), .clr(good_pkt), .en(1'b1), .timeout(link_to)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    good_pkt   = 1'b0;
    bad_pkt    = 1'b0;
    byte_abort = 1'b0;
    rsv_bad    = 1'b0;
    case (state)
      HUNT: if (rx.rx_valid && rx.rx_data == SYNC_BYTE) state_nxt = X_HI;
      CHK: if (rx.rx_valid) begin
        state_nxt = HUNT;
        if ((chk_acc ^ rx.rx_data) == 8'h00 && !rsv_err) good_pkt = 1'b1;
        else                                             bad_pkt  = 1'b1;
      end
      default: if (rx.rx_valid) state_nxt = rx_state_t'(state + 1'b1);
    endcase
    case (state)
      X_HI:       rsv_bad = |rx.rx_data[7:X_W-8];
      Y_HI, P_HI: rsv_bad = |rx.rx_data[7:Y_W-8];
      default:    rsv_bad = 1'b0;
    endcase
    // A byte arriving on the timeout cycle wins over the abort.
    if (state != HUNT && !rx.rx_valid && byte_to) begin
      state_nxt  = HUNT;
      byte_abort = 1'b1;
    end
  end

  // NOTE: shadow registers are never visible before a complete checked packet rewrites them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rx.rx_valid) begin
      case (state)
        X_HI:    x_sh[X_W-1:8] <= rx.rx_data[X_W-9:0];
        X_LO:    x_sh[7:0]     <= rx.rx_data;
        Y_HI:    y_sh[Y_W-1:8] <= rx.rx_data[Y_W-9:0];
        Y_LO:    y_sh[7:0]     <= rx.rx_data;
        P_HI:    p_sh[Y_W-1:8] <= rx.rx_data[Y_W-9:0];
        P_LO:    p_sh[7:0]     <= rx.rx_data;
        SCORE:   score_sh      <= rx.rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_acc <= 8'h00;
      rsv_err <= 1'b0;
    end else if (rx.rx_valid) begin
      if (state == HUNT) begin
        chk_acc <= 8'h00;
        rsv_err <= 1'b0;
      end else if (state != CHK) begin
        chk_acc <= chk_acc ^ rx.rx_data;
        rsv_err <= rsv_err | rsv_bad;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_ball        <= '0;
      y_ball        <= '0;
      y_player_1    <= '0;
      player1_score <= '0;
      player2_score <= '0;
      frame_valid   <= 1'b0;
      frame_err     <= 1'b0;
      err_count     <= 8'h00;
      link_up       <= 1'b0;
    end else begin
      frame_valid <= good_pkt;
      frame_err   <= bad_pkt || byte_abort;
      if (good_pkt) begin
        x_ball                           <= x_sh;
        y_ball                           <= y_sh;
        y_player_1                       <= p_sh;
        {player1_score, player2_score}   <= score_sh;
      end
      if ((bad_pkt || byte_abort) && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      if (good_pkt)     link_up <= 1'b1;
      else if (link_to) link_up <= 1'b0;
    end
  end

endmodule

// File: tb/tb_game_state_rx.sv
// Randomized, model-checked bench for the game-state receiver with short timeouts.
module tb_game_state_rx;
  import game_state_rx_pkg::*;

  localparam int BYTE_TO = 50;
  localparam int LINK_TO = 3000;

  typedef logic [7:0] pkt_t [0:8];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_state_rx_if rx();

  logic [10:0] x_ball;
  logic [9:0]  y_ball, y_player_1;
  logic [3:0]  player1_score, player2_score;
  logic        frame_valid, frame_err, link_up;
  logic [7:0]  err_count;

  game_state_rx #(.BYTE_TIMEOUT(BYTE_TO), .LINK_TIMEOUT(LINK_TO)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .x_ball(x_ball), .y_ball(y_ball), .y_player_1(y_player_1),
    .player1_score(player1_score), .player2_score(player2_score),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .err_count(err_count), .link_up(link_up)
  );

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0, fe_cnt = 0;
  int exp_fv = 0, exp_fe = 0;

  logic [10:0] ex;
  logic [9:0]  ey, ep;
  logic [3:0]  es1, es2;
  logic [7:0]  eerr;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_err)   fe_cnt++;
  end

  function automatic logic [46:0] exp_vec();
    return {ex, ey, ep, es1, es2, eerr};
  endfunction

  function automatic logic [46:0] obs_vec();
    return {x_ball, y_ball, y_player_1, player1_score, player2_score, err_count};
  endfunction

  function automatic pkt_t fix_chk(input pkt_t pk);
    pkt_t r = pk;
    r[8] = 8'h00;
    for (int i = 1; i <= 7; i++) r[8] ^= r[i];
    return r;
  endfunction

  function automatic pkt_t build_pkt(input logic [10:0] x, input logic [9:0] y,
                                     input logic [9:0] p, input logic [7:0] sc);
    pkt_t r;
    r[0] = SYNC_BYTE;
    r[1] = {5'b0, x[10:8]}; r[2] = x[7:0];
    r[3] = {6'b0, y[9:8]};  r[4] = y[7:0];
    r[5] = {6'b0, p[9:8]};  r[6] = p[7:0];
    r[7] = sc;
    r[8] = 8'h00;
    return fix_chk(r);
  endfunction

  // Reference judgement straight from the packet rules.
  task automatic model_packet(input pkt_t pk);
    logic [7:0] c = 8'h00;
    logic good;
    for (int i = 1; i <= 7; i++) c ^= pk[i];
    good = (c == pk[8]) && (pk[1][7:3] == 0) && (pk[3][7:2] == 0) && (pk[5][7:2] == 0);
    if (good) begin
      ex = {pk[1][2:0], pk[2]};
      ey = {pk[3][1:0], pk[4]};
      ep = {pk[5][1:0], pk[6]};
      {es1, es2} = pk[7];
      exp_fv++;
    end else begin
      if (eerr != 8'hFF) eerr++;
      exp_fe++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx.rx_data  = b;
    rx.rx_valid = 1'b1;
    @(posedge clk); #1;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'($urandom);
    idle(gap);
  endtask

  task automatic send_pkt(input pkt_t pk, input int max_gap);
    for (int i = 0; i < 9; i++)
      send_byte(pk[i], (i == 8) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx.rx_valid = 1'b0;
    rx.rx_data  = 8'h00;
    ex = '0; ey = '0; ep = '0; es1 = '0; es2 = '0; eerr = '0;
    idle(3);
    checks++;
    if ({obs_vec(), frame_valid, frame_err, link_up} !== {47'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: got %h/%b%b%b required 0/000", obs_vec(), frame_valid, frame_err, link_up);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_packet();
    pkt_t pk = '{8'hA5, 8'h01, 8'h90, 8'h01, 8'h2C, 8'h00, 8'hFA, 8'h37, 8'h71};
    send_pkt(pk, 0);
    model_packet(pk);
    idle(2);
    checks++;
    if ({x_ball, y_ball, y_player_1, player1_score, player2_score} !==
        {11'd400, 10'd300, 10'd250, 4'd3, 4'd7}) begin
      errors++;
      $display("FAIL good_packet: got x=%0d y=%0d p=%0d s=%0d/%0d required 400/300/250/3/7",
               x_ball, y_ball, y_player_1, player1_score, player2_score);
    end
    checks++;
    if (fv_cnt !== 1 || fe_cnt !== 0 || link_up !== 1'b1) begin
      errors++;
      $display("FAIL good_packet_pulse: got fv=%0d fe=%0d link=%b required 1 0 1", fv_cnt, fe_cnt, link_up);
    end
  endtask

  task automatic test_bad_checksum();
    pkt_t pk = '{8'hA5, 8'h01, 8'h90, 8'h01, 8'h2C, 8'h00, 8'hFA, 8'h37, 8'h70};
    send_pkt(pk, 2);
    model_packet(pk);
    idle(2);
    checks++;
    if (obs_vec() !== {11'd400, 10'd300, 10'd250, 4'd3, 4'd7, 8'd1} || fe_cnt !== 1) begin
      errors++;
      $display("FAIL bad_checksum: got %h fe=%0d required %h fe=1", obs_vec(), fe_cnt, exp_vec());
    end
  endtask

  task automatic test_reserved_bit();
    pkt_t pk = '{8'hA5, 8'h09, 8'h90, 8'h01, 8'h2C, 8'h00, 8'hFA, 8'h37, 8'h00};
    pk = fix_chk(pk);
    send_pkt(pk, 2);
    model_packet(pk);
    idle(2);
    checks++;
    if (obs_vec() !== exp_vec() || err_count !== 8'd2 || fe_cnt !== exp_fe) begin
      errors++;
      $display("FAIL reserved_bit: got %h fe=%0d required %h fe=%0d", obs_vec(), fe_cnt, exp_vec(), exp_fe);
    end
  endtask

  task automatic test_garbage();
    pkt_t pk = build_pkt(11'd1234, 10'd567, 10'd89, 8'h9C);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h12, 1);
    send_pkt(pk, 3);
    model_packet(pk);
    idle(2);
    checks++;
    if (obs_vec() !== exp_vec() || fe_cnt !== exp_fe || fv_cnt !== exp_fv) begin
      errors++;
      $display("FAIL garbage_then_packet: got %h fv=%0d fe=%0d required %h fv=%0d fe=%0d",
               obs_vec(), fv_cnt, fe_cnt, exp_vec(), exp_fv, exp_fe);
    end
  endtask

  task automatic test_byte_timeout();
    pkt_t pk = build_pkt(11'd7, 10'd1023, 10'd512, 8'hF0);
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h01, 0);
    send_byte(8'h90, 0);
    idle(BYTE_TO + 5);
    exp_fe++;
    eerr++;
    checks++;
    if (fe_cnt !== exp_fe || err_count !== eerr || fv_cnt !== exp_fv) begin
      errors++;
      $display("FAIL byte_timeout: got fe=%0d err=%0d fv=%0d required fe=%0d err=%0d fv=%0d",
               fe_cnt, err_count, fv_cnt, exp_fe, eerr, exp_fv);
    end
    send_pkt(pk, 4);
    model_packet(pk);
    idle(2);
    checks++;
    if (obs_vec() !== exp_vec() || fv_cnt !== exp_fv) begin
      errors++;
      $display("FAIL after_timeout: got %h fv=%0d required %h fv=%0d", obs_vec(), fv_cnt, exp_vec(), exp_fv);
    end
  endtask

  // Every gap lands the next byte on exactly the cycle the gap counter hits its limit.
  task automatic test_gap_boundary();
    pkt_t pk = build_pkt(11'd2047, 10'd0, 10'd1, 8'h5A);
    for (int i = 0; i < 9; i++) send_byte(pk[i], (i == 8) ? 0 : BYTE_TO);
    model_packet(pk);
    idle(2);
    checks++;
    if (obs_vec() !== exp_vec() || fe_cnt !== exp_fe || fv_cnt !== exp_fv) begin
      errors++;
      $display("FAIL gap_boundary: got %h fv=%0d fe=%0d required %h fv=%0d fe=%0d",
               obs_vec(), fv_cnt, fe_cnt, exp_vec(), exp_fv, exp_fe);
    end
  endtask

  task automatic test_back_to_back();
    pkt_t a = build_pkt(11'd100, 10'd200, 10'd300, 8'h12);
    pkt_t b = build_pkt(11'd5, 10'd6, 10'd7, 8'h89);
    a[2] = SYNC_BYTE;
    a = fix_chk(a);
    send_pkt(a, 0);
    model_packet(a);
    send_pkt(b, 0);
    model_packet(b);
    idle(2);
    checks++;
    if (obs_vec() !== exp_vec() || fv_cnt !== exp_fv || fe_cnt !== exp_fe) begin
      errors++;
      $display("FAIL back_to_back: got %h fv=%0d fe=%0d required %h fv=%0d fe=%0d",
               obs_vec(), fv_cnt, fe_cnt, exp_vec(), exp_fv, exp_fe);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      pkt_t pk = build_pkt(11'($urandom), 10'($urandom), 10'($urandom), 8'($urandom));
      case ($urandom_range(0, 5))
        0: pk[8] ^= 8'(1 << $urandom_range(0, 7));
        1: begin pk[1][3 + $urandom_range(0, 4)] = 1'b1; pk = fix_chk(pk); end
        2: begin pk[3][2 + $urandom_range(0, 5)] = 1'b1; pk = fix_chk(pk); end
        3: begin pk[5][2 + $urandom_range(0, 5)] = 1'b1; pk = fix_chk(pk); end
        default: ;
      endcase
      send_pkt(pk, 8);
      model_packet(pk);
      idle(2);
      checks++;
      if (obs_vec() !== exp_vec() || fv_cnt !== exp_fv || fe_cnt !== exp_fe) begin
        errors++;
        $display("FAIL random_pkt_%0d: got %h fv=%0d fe=%0d required %h fv=%0d fe=%0d",
                 n, obs_vec(), fv_cnt, fe_cnt, exp_vec(), exp_fv, exp_fe);
      end
    end
  endtask

  task automatic test_link_timeout();
    pkt_t pk = build_pkt(11'd640, 10'd480, 10'd240, 8'h21);
    send_pkt(pk, 1);
    model_packet(pk);
    idle(2);
    idle(LINK_TO - 30);
    checks++;
    if (link_up !== 1'b1) begin
      errors++;
      $display("FAIL link_hold: got link_up=%b required 1", link_up);
    end
    idle(60);
    checks++;
    if (link_up !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL link_drop: got link_up=%b state=%h required 0 state=%h", link_up, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_packet();
    pkt_t pk = build_pkt(11'd321, 10'd654, 10'd987, 8'h46);
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h01, 0);
    send_byte(8'h90, 0);
    send_byte(8'h01, 0);
    rst = 1'b1;
    #1;
    ex = '0; ey = '0; ep = '0; es1 = '0; es2 = '0; eerr = '0;
    checks++;
    if ({obs_vec(), link_up} !== 48'd0) begin
      errors++;
      $display("FAIL reset_mid_packet: got %h link=%b required 0", obs_vec(), link_up);
    end
    idle(2);
    rst = 1'b0;
    idle(1);
    send_pkt(pk, 2);
    model_packet(pk);
    idle(2);
    checks++;
    if (obs_vec() !== exp_vec() || fe_cnt !== exp_fe || fv_cnt !== exp_fv || link_up !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: got %h fv=%0d fe=%0d required %h fv=%0d fe=%0d",
               obs_vec(), fv_cnt, fe_cnt, exp_vec(), exp_fv, exp_fe);
    end
  endtask

  task automatic test_err_saturation();
    for (int n = 0; n < 260; n++) begin
      pkt_t pk = build_pkt(11'($urandom), 10'($urandom), 10'($urandom), 8'($urandom));
      pk[8] ^= 8'h01;
      send_pkt(pk, 0);
      model_packet(pk);
    end
    idle(2);
    checks++;
    if (err_count !== 8'hFF || eerr !== 8'hFF || fe_cnt !== exp_fe || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL err_saturation: got err=%0d fe=%0d required err=255 fe=%0d", err_count, fe_cnt, exp_fe);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_reserved_bit();
    test_garbage();
    test_byte_timeout();
    test_gap_boundary();
    test_back_to_back();
    test_random();
    test_link_timeout();
    test_reset_mid_packet();
    test_err_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
